// File: rtl/player_ctrl.sv
// Player ship: tick-divided clamped movement, lives/invulnerability FSM with blink, 2-stage sprite pixel pipeline.
// Pixel latency 2 cycles from i_x/i_y to o_rgb_out/o_player_on; no backpressure, one pixel accepted every cycle.
module player_ctrl #(
  parameter int FIELD_W      = 384,
  parameter int FIELD_H      = 448,
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 48,
  parameter int START_X      = 192,
  parameter int START_Y      = 400,
  parameter int TICK_DIV     = 2000000,
  parameter int FAST_STEP    = 3,
  parameter int SLOW_STEP    = 1,
  parameter int LIVES        = 3,
  parameter int INVULN_TICKS = 120,
  parameter int BLINK_TICKS  = 8,
  parameter logic [11:0] TRANSP = 12'hCCC,
  parameter int ADDR_W       = $clog2(SPR_W*SPR_H) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_ctrl_up,
  input  logic              i_ctrl_down,
  input  logic              i_ctrl_left,
  input  logic              i_ctrl_right,
  input  logic              i_ctrl_slow,
  input  logic              i_collision,
  input  logic [11:0]       i_rom_data,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [9:0]        o_player_x,
  output logic [9:0]        o_player_y,
  output logic [11:0]       o_rgb_out,
  output logic              o_player_on,
  output logic [2:0]        o_lives,
  output logic              o_invuln,
  output logic              o_hit_pulse,
  output logic              o_game_over
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(INVULN_TICKS + 1);
  localparam int OFF_W = ADDR_W - 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  localparam logic signed [10:0] X_MIN = 11'(SPR_W / 2);
  localparam logic signed [10:0] X_MAX = 11'(FIELD_W - SPR_W / 2);
  localparam logic signed [10:0] Y_MIN = 11'(SPR_H / 2);
  localparam logic signed [10:0] Y_MAX = 11'(FIELD_H - SPR_H / 2);
  localparam logic signed [11:0] HALF_W = 12'(SPR_W / 2);
  localparam logic signed [11:0] HALF_H = 12'(SPR_H / 2);
  localparam logic signed [11:0] SPR_W_S = 12'(SPR_W);
  localparam logic signed [11:0] SPR_H_S = 12'(SPR_H);

  typedef enum logic [1:0] {ST_ALIVE, ST_INVULN, ST_OVER} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [9:0]        r_x, r_y, w_x_nxt, w_y_nxt;
  logic [2:0]        r_lives, w_lives_nxt;
  logic              r_hit, w_hit_nxt;
  logic              w_tick;

  logic signed [10:0] w_step, w_dx, w_dy, w_mx, w_my, w_cx, w_cy;

  logic signed [11:0] w_ox, w_oy;
  logic [OFF_W-1:0]   w_off;
  logic               w_in_box, w_hide, w_visible;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_in_box, r_vis1;
  logic [11:0]        r_rgb;
  logic               r_on;

  assign w_tick = (r_div == DIV_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Opposing directions cancel; 11-bit signed math lets the clamp see values below zero.
  always_comb begin
    w_step = i_ctrl_slow ? 11'(SLOW_STEP) : 11'(FAST_STEP);
    w_dx = '0;
    w_dy = '0;
    if (i_ctrl_right && !i_ctrl_left)      w_dx = w_step;
    else if (i_ctrl_left && !i_ctrl_right) w_dx = -w_step;
    if (i_ctrl_down && !i_ctrl_up)         w_dy = w_step;
    else if (i_ctrl_up && !i_ctrl_down)    w_dy = -w_step;
    w_mx = $signed({1'b0, r_x}) + w_dx;
    w_my = $signed({1'b0, r_y}) + w_dy;
    w_cx = (w_mx < X_MIN) ? X_MIN : ((w_mx > X_MAX) ? X_MAX : w_mx);
    w_cy = (w_my < Y_MIN) ? Y_MIN : ((w_my > Y_MAX) ? Y_MAX : w_my);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    w_hit_nxt   = 1'b0;
    case (r_state)
      ST_ALIVE: begin
        if (i_collision) begin
          // A hit wins over a coincident tick: that tick's movement is dropped.
          w_hit_nxt   = 1'b1;
          w_lives_nxt = r_lives - 3'd1;
          if (r_lives == 3'd1) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_INVULN;
            w_cnt_nxt   = CNT_W'(INVULN_TICKS);
            w_x_nxt     = 10'(START_X);
            w_y_nxt     = 10'(START_Y);
          end
        end else if (w_tick) begin
          w_x_nxt = w_cx[9:0];
          w_y_nxt = w_cy[9:0];
        end
      end
      ST_INVULN: begin
        if (w_tick) begin
          w_x_nxt = w_cx[9:0];
          w_y_nxt = w_cy[9:0];
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ALIVE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      ST_OVER: begin
      end
      default: w_state_nxt = ST_ALIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ALIVE;
      r_x     <= 10'(START_X);
      r_y     <= 10'(START_Y);
      r_lives <= 3'(LIVES);
      r_cnt   <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_lives <= w_lives_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hit   <= w_hit_nxt;
    end
  end

  always_comb begin
    w_ox      = $signed({2'b00, i_x}) - $signed({2'b00, r_x}) + HALF_W;
    w_oy      = $signed({2'b00, i_y}) - $signed({2'b00, r_y}) + HALF_H;
    w_in_box  = (w_ox >= 12'sd0) && (w_ox < SPR_W_S) && (w_oy >= 12'sd0) && (w_oy < SPR_H_S);
    w_off     = OFF_W'($unsigned(w_oy)) * OFF_W'(SPR_W) + OFF_W'($unsigned(w_ox));
    w_hide    = ((int'(r_cnt) / BLINK_TICKS) % 2) != 0;
    w_visible = !((r_state == ST_INVULN) && w_hide);
  end

  // Stage 1 latches the box test and ROM address; stage 2 samples the asynchronous ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_in_box   <= 1'b0;
      r_vis1     <= 1'b0;
      r_rgb      <= '0;
      r_on       <= 1'b0;
    end else begin
      r_rom_addr <= w_in_box ? {(r_state == ST_INVULN), w_off} : '0;
      r_in_box   <= w_in_box;
      r_vis1     <= w_visible;
      r_rgb      <= r_in_box ? i_rom_data : 12'h000;
      r_on       <= r_in_box && (i_rom_data != TRANSP) && r_vis1 && (r_state != ST_OVER);
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_player_x  = r_x;
  assign o_player_y  = r_y;
  assign o_rgb_out   = r_rgb;
  assign o_player_on = r_on;
  assign o_lives     = r_lives;
  assign o_invuln    = (r_state == ST_INVULN);
  assign o_hit_pulse = r_hit;
  assign o_game_over = (r_state == ST_OVER);

endmodule
